// File: rtl/count_sequence_checker.sv
// Sequence checker for an up-counter bus: predicts count+1 each sample,
// tallies errors and verified wraps, and re-locks after a break.
module count_sequence_checker #(
  parameter int WIDTH      = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8,
  parameter int RESYNC_LEN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  sample_en,
  input  logic                  clr_err,
  output logic                  locked,
  output logic                  mismatch,
  output logic                  err_sticky,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic [WIDTH-1:0]      expected
);

  typedef enum logic [1:0] {
    ACQUIRE,
    TRACK,
    RESYNC
  } state_t;

  state_t           state;
  logic [3:0]       run;
  logic             hit;
  logic             err_hit;
  logic             run_done;
  logic             at_top;
  logic [WIDTH-1:0] nxt;

  always_comb begin
    hit      = (count_in == expected);
    nxt      = count_in + WIDTH'(1);
    at_top   = (count_in == '1);
    run_done = ({1'b0, run} + 5'd1) == 5'(RESYNC_LEN);
    // RESYNC misses are part of the same loss of lock, so never counted
    err_hit  = sample_en && !hit && (state != RESYNC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ACQUIRE;
      run        <= '0;
      locked     <= 1'b0;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
      expected   <= '0;
    end else begin
      mismatch <= err_hit;

      if (err_hit) begin
        err_sticky <= 1'b1;
        if (clr_err)
          err_count <= ERR_CNT_W'(1);
        else if (err_count != '1)
          err_count <= err_count + ERR_CNT_W'(1);
      end else if (clr_err) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end

      if (sample_en) begin
        case (state)
          ACQUIRE: begin
            if (hit) begin
              state    <= TRACK;
              locked   <= 1'b1;
              expected <= nxt;
            end
          end
          TRACK: begin
            expected <= nxt;
            if (hit) begin
              if (at_top && wrap_count != '1)
                wrap_count <= wrap_count + WRAP_CNT_W'(1);
            end else if (RESYNC_LEN == 1) begin
              run <= '0;
            end else begin
              state  <= RESYNC;
              locked <= 1'b0;
              run    <= 4'd1;
            end
          end
          RESYNC: begin
            expected <= nxt;
            if (!hit) begin
              run <= 4'd1;
            end else if (run_done) begin
              state  <= TRACK;
              locked <= 1'b1;
              run    <= '0;
            end else begin
              run <= run + 4'd1;
            end
          end
          default: begin
            state    <= ACQUIRE;
            locked   <= 1'b0;
            run      <= '0;
            expected <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_sequence_checker.sv
// Scoreboard bench: driver queues hand-computed expectations,
// monitor pops and compares them after each clock or reset edge.
module tb_count_sequence_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] count_in = '0;
  logic       sample_en = 1'b0;
  logic       clr_err = 1'b0;

  logic       locked, mismatch, err_sticky;
  logic [7:0] err_count, wrap_count;
  logic [3:0] expected;

  logic       locked2, mismatch2, err_sticky2;
  logic [1:0] err_count2;
  logic [7:0] wrap_count2;
  logic [3:0] expected2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string nm;
    int    l, m, s, e, w, x, e2;
  } item_t;

  item_t q[$];

  always #5 clk = ~clk;

  count_sequence_checker #(
    .WIDTH(4), .ERR_CNT_W(8), .WRAP_CNT_W(8), .RESYNC_LEN(2)
  ) dut (
    .clk(clk), .rst(rst), .count_in(count_in),
    .sample_en(sample_en), .clr_err(clr_err),
    .locked(locked), .mismatch(mismatch),
    .err_sticky(err_sticky), .err_count(err_count),
    .wrap_count(wrap_count), .expected(expected)
  );

  count_sequence_checker #(
    .WIDTH(4), .ERR_CNT_W(2), .WRAP_CNT_W(8), .RESYNC_LEN(2)
  ) dut2 (
    .clk(clk), .rst(rst), .count_in(count_in),
    .sample_en(sample_en), .clr_err(clr_err),
    .locked(locked2), .mismatch(mismatch2),
    .err_sticky(err_sticky2), .err_count(err_count2),
    .wrap_count(wrap_count2), .expected(expected2)
  );

  function automatic void chk(string nm, string f, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s.%s: got %0d want %0d", nm, f, got, want);
    end
  endfunction

  initial begin
    item_t it;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      while (q.size() > 0) begin
        it = q.pop_front();
        chk(it.nm, "locked", int'(locked), it.l);
        chk(it.nm, "mismatch", int'(mismatch), it.m);
        chk(it.nm, "err_sticky", int'(err_sticky), it.s);
        chk(it.nm, "err_count", int'(err_count), it.e);
        chk(it.nm, "wrap_count", int'(wrap_count), it.w);
        chk(it.nm, "expected", int'(expected), it.x);
        if (it.e2 >= 0) begin
          chk(it.nm, "err_count2", int'(err_count2), it.e2);
          chk(it.nm, "err_sticky2", int'(err_sticky2), it.s);
        end
      end
    end
  end

  function automatic void push(string nm, int l, int m, int s,
                               int e, int w, int x, int e2);
    item_t it;
    it.nm = nm; it.l = l; it.m = m; it.s = s;
    it.e = e; it.w = w; it.x = x; it.e2 = e2;
    q.push_back(it);
  endfunction

  task automatic step(input string nm, input logic [3:0] c,
                      input logic en, input logic clr,
                      input int l, input int m, input int s,
                      input int e, input int w, input int x,
                      input int e2 = -1);
    @(negedge clk);
    count_in  = c;
    sample_en = en;
    clr_err   = clr;
    @(posedge clk);
    push(nm, l, m, s, e, w, x, e2);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    @(negedge clk);
    push("reset_init", 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    release_rst();

    for (int i = 0; i < 16; i++)
      step("count_up", 4'(i), 1, 0, 1, 0, 0, 0,
           (i == 15) ? 1 : 0, (i + 1) % 16);
    step("wrap_zero", 4'd0, 1, 0, 1, 0, 0, 0, 1, 1);

    step("trk_1", 4'd1, 1, 0, 1, 0, 0, 0, 1, 2);
    step("trk_2", 4'd2, 1, 0, 1, 0, 0, 0, 1, 3);
    step("trk_3", 4'd3, 1, 0, 1, 0, 0, 0, 1, 4);
    step("trk_4", 4'd4, 1, 0, 1, 0, 0, 0, 1, 5);
    step("break_9", 4'd9, 1, 0, 0, 1, 1, 1, 1, 10);
    step("relock_10", 4'd10, 1, 0, 1, 0, 1, 1, 1, 11);
    step("trk_11", 4'd11, 1, 0, 1, 0, 1, 1, 1, 12);

    step("break_5", 4'd5, 1, 0, 0, 1, 1, 2, 1, 6);
    step("rs_9", 4'd9, 1, 0, 0, 0, 1, 2, 1, 10);
    step("rs_2", 4'd2, 1, 0, 0, 0, 1, 2, 1, 3);
    step("rs_3", 4'd3, 1, 0, 1, 0, 1, 2, 1, 4);

    step("gap_4", 4'd4, 1, 0, 1, 0, 1, 2, 1, 5);
    step("gap_5", 4'd5, 1, 0, 1, 0, 1, 2, 1, 6);
    step("gap_off_a", 4'd9, 0, 0, 1, 0, 1, 2, 1, 6);
    step("gap_6", 4'd6, 1, 0, 1, 0, 1, 2, 1, 7);
    step("gap_off_b", 4'd0, 0, 0, 1, 0, 1, 2, 1, 7);
    step("gap_7", 4'd7, 1, 0, 1, 0, 1, 2, 1, 8);
    step("clr_idle", 4'd3, 0, 1, 1, 0, 0, 0, 1, 8);
    step("clr_and_err", 4'd12, 1, 1, 0, 1, 1, 1, 1, 13);

    @(negedge clk);
    sample_en = 1'b0;
    clr_err   = 1'b0;
    #2;
    rst = 1'b0;
    push("async_reset", 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    release_rst();

    step("acq_err", 4'd5, 1, 0, 0, 1, 1, 1, 0, 0, 1);
    step("acq_lock", 4'd0, 1, 0, 1, 0, 1, 1, 0, 1, 1);
    for (int k = 1; k <= 5; k++) begin
      n = 1 + k;
      step("sat_break", 4'd8, 1, 0, 0, 1, 1, n, 0, 9,
           (n > 3) ? 3 : n);
      step("sat_relock", 4'd9, 1, 0, 1, 0, 1, n, 0, 10,
           (n > 3) ? 3 : n);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
